// File: rtl/spi_peripheral.sv
// SPI mode-0 target endpoint. SCLK, CS_N and MOSI are oversampled in the
// i_clk domain. Frames are shifted MSB-first. MISO is fed from a one-entry
// TX holding buffer, and each completed RX word is presented with a
// single-cycle valid pulse.
//
// TX handshake: a word is accepted on any i_clk edge where i_tx_valid and
// o_tx_ready are both 1. o_tx_ready drops while the buffer holds a word and
// rises again the cycle after that word is loaded into the shift register.
// A strobe seen while o_tx_ready is 0 is dropped. The RX side has no
// backpressure: o_rx_valid pulses once per word, and an unread word is
// overwritten by the next one.
module spi_peripheral #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sclk,
    input  logic             i_cs_n,
    input  logic             i_mosi,
    output logic             o_miso,
    output logic             o_miso_oe,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    output logic             o_tx_underrun,
    output logic             o_busy
);

    localparam int CW = $clog2(WIDTH + 1);

    // o_busy is the externally visible copy of this state.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_dly_q, cs_dly_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_t             state_q, state_d;
    logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   tx_sr_q, tx_sr_d;
    logic [WIDTH-2:0]   rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0]   rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               underrun_q, underrun_d;
    logic               miso_q, miso_d;
    logic [WIDTH-1:0]   buf_q, buf_d;
    logic               buf_full_q, buf_full_d;
    logic               tx_write, load;
    logic [WIDTH-1:0]   rx_word;

    // Synchronizer chains plus one extra delayed copy used for edge detection.
    // CS_N idles high so that a reset never produces a false select.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
            cs_dly_q    <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign cs_rise   = cs_s & ~cs_dly_q;
    assign cs_fall   = ~cs_s & cs_dly_q;
    assign tx_write  = i_tx_valid & ~buf_full_q;
    assign rx_word   = {rx_sr_q, mosi_s};

    // Next-state logic for the frame FSM, the shift registers and the TX buffer.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        miso_d     = miso_q;
        load       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    load      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (sclk_rise) begin
                    rx_sr_d = rx_word[WIDTH-2:0];
                    if (bit_cnt_q == CW'(WIDTH - 1)) begin
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall && !cs_rise) begin
                    // A fall at count 0 is a frame boundary with CS still
                    // low, so the next word is reloaded for back-to-back frames.
                    if (bit_cnt_q != '0) begin
                        tx_sr_d = tx_sr_q << 1;
                        miso_d  = tx_sr_q[WIDTH-2];
                    end else begin
                        load = 1'b1;
                    end
                end
                // Deselect wins over any pending reload. A rise in the same
                // cycle has already been handled above.
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    miso_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            if (buf_full_q) begin
                tx_sr_d = buf_q;
                miso_d  = buf_q[WIDTH-1];
            end else begin
                tx_sr_d    = '0;
                miso_d     = 1'b0;
                underrun_d = 1'b1;
            end
        end

        // A write can only be accepted while the buffer is empty, so it never
        // collides with a load that consumes the buffer.
        buf_d      = tx_write ? i_tx_data : buf_q;
        buf_full_d = tx_write ? 1'b1 : (load ? 1'b0 : buf_full_q);
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            miso_q     <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
            miso_q     <= miso_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end

    assign o_miso        = miso_q;
    assign o_miso_oe     = (state_q == ST_ACTIVE);
    assign o_busy        = (state_q == ST_ACTIVE);
    assign o_tx_ready    = ~buf_full_q;
    assign o_rx_data     = rx_data_q;
    assign o_rx_valid    = rx_valid_q;
    assign o_tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: acts as the SPI controller and checks
// MISO words, received words, the TX buffer handshake and the underrun pulses.
module tb_spi_peripheral;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sclk = 1'b0;
    logic         cs_n = 1'b1;
    logic         mosi = 1'b0;
    logic         miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic [W-1:0] rx_data;

    int           n_checks = 0;
    int           n_fail = 0;
    int           ur_cnt = 0;
    logic         prev_rx_valid = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got;
    int           ur_base;

    spi_peripheral #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
        .o_miso(miso), .o_miso_oe(miso_oe), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
        .o_tx_underrun(tx_underrun), .o_busy(busy)
    );

    // Clock: 10 ns period, posedges at 5, 15, ... and negedges on multiples of 10.
    always #5 clk = ~clk;

    // Global time bound.
    initial begin
        #2ms;
        $display("FAIL timeout: simulation still running at 2 ms, required end before");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each rx_valid pulse pops the expected word; pulses are single-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                check("rx_pulse_single", prev_rx_valid, 1'b0);
                check("rx_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("rx_data", rx_data, exp_q.pop_front());
            end
            if (tx_underrun) ur_cnt++;
        end
        prev_rx_valid <= rx_valid;
    end

    task automatic tx_write(input logic [W-1:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic select(input int half_ns);
        cs_n = 1'b0;
        #(half_ns);
    endtask

    // Send the first nbits of w MSB-first; SCLK is left low and CS left low.
    task automatic spi_bits(input logic [W-1:0] w, input int nbits, input int half_ns);
        for (int i = W - 1; i >= W - nbits; i--) begin
            mosi = w[i];
            #(half_ns);
            sclk = 1'b1;
            #(half_ns);
            sclk = 1'b0;
        end
    endtask

    // Full frame. end_mode 0: keep CS low, 1: raise CS with the last SCLK fall,
    // 2: raise CS with the last SCLK rise. MISO is sampled just before each rise.
    task automatic spi_frame(input logic [W-1:0] w, input int end_mode, input int half_ns,
                             output logic [W-1:0] miso_w);
        for (int i = W - 1; i >= 0; i--) begin
            mosi = w[i];
            #(half_ns);
            miso_w[i] = miso;
            sclk = 1'b1;
            if (i == 0 && end_mode == 2) cs_n = 1'b1;
            #(half_ns);
            sclk = 1'b0;
            if (i == 0 && end_mode == 1) cs_n = 1'b1;
        end
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_miso", miso, 1'b0);
        check("rst_oe", miso_oe, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame: MISO 0xA5, MOSI 0x3C at SCLK = clk/16
        tx_write(8'hA5);
        check("t2_ready_low", tx_ready, 1'b0);
        ur_base = ur_cnt;
        select(80);
        check("t2_ready_after_cs", tx_ready, 1'b1);
        check("t2_busy", busy, 1'b1);
        check("t2_oe", miso_oe, 1'b1);
        exp_q.push_back(8'h3C);
        spi_frame(8'h3C, 1, 80, got);
        check("t2_miso_word", got, 8'hA5);
        repeat (10) @(negedge clk);
        check("t2_rx_data", rx_data, 8'h3C);
        check("t2_underruns", ur_cnt - ur_base, 0);
        check("t2_idle_oe", miso_oe, 1'b0);
        check("t2_idle_miso", miso, 1'b0);

        // Reset mid-frame with a second word still buffered
        tx_write(8'h11);
        select(80);
        tx_write(8'h22);
        check("t1_buffered", tx_ready, 1'b0);
        spi_bits(8'hF0, 4, 80);
        #7;
        rst_n = 1'b0;
        #1;
        check("t1_miso", miso, 1'b0);
        check("t1_oe", miso_oe, 1'b0);
        check("t1_tx_ready", tx_ready, 1'b1);
        check("t1_rx_data", rx_data, 8'h00);
        check("t1_rx_valid", rx_valid, 1'b0);
        check("t1_underrun", tx_underrun, 1'b0);
        check("t1_busy", busy, 1'b0);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Back-to-back frames with CS held low
        tx_write(8'h81);
        ur_base = ur_cnt;
        select(80);
        tx_write(8'h7E);
        check("t3_ready_low", tx_ready, 1'b0);
        exp_q.push_back(8'h12);
        spi_frame(8'h12, 0, 80, got);
        check("t3_miso_1", got, 8'h81);
        check("t3_busy_between", busy, 1'b1);
        exp_q.push_back(8'h34);
        spi_frame(8'h34, 1, 80, got);
        check("t3_miso_2", got, 8'h7E);
        repeat (10) @(negedge clk);
        check("t3_rx_data", rx_data, 8'h34);
        check("t3_underruns", ur_cnt - ur_base, 0);
        check("t3_ready", tx_ready, 1'b1);

        // Underrun: no TX word written
        ur_base = ur_cnt;
        select(80);
        exp_q.push_back(8'hF0);
        spi_frame(8'hF0, 1, 80, got);
        check("t4_miso_word", got, 8'h00);
        repeat (10) @(negedge clk);
        check("t4_underruns", ur_cnt - ur_base, 1);
        check("t4_rx_data", rx_data, 8'hF0);

        // Aborted frame after 5 rises, then a full frame
        select(80);
        spi_bits(8'hAA, 5, 80);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        check("t5_oe", miso_oe, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_rx_data_held", rx_data, 8'hF0);
        tx_write(8'hC9);
        select(80);
        exp_q.push_back(8'h55);
        spi_frame(8'h55, 1, 80, got);
        check("t5_miso_word", got, 8'hC9);
        repeat (10) @(negedge clk);
        check("t5_rx_data", rx_data, 8'h55);

        // CS rise coincident with the final SCLK rise: word still delivered
        tx_write(8'h3A);
        select(80);
        exp_q.push_back(8'hC3);
        spi_frame(8'hC3, 2, 80, got);
        check("t7_miso_word", got, 8'h3A);
        repeat (10) @(negedge clk);
        check("t7_rx_data", rx_data, 8'hC3);
        check("t7_busy", busy, 1'b0);

        // Minimum SCLK high/low (5 clk) with a random phase, 8 frames
        for (int f = 0; f < 8; f++) begin
            logic [W-1:0] tw, rw;
            int ph;
            tw = W'($urandom_range(0, 255));
            rw = W'($urandom_range(0, 255));
            tx_write(tw);
            ph = $urandom_range(1, 8);
            if (ph >= 5) ph++;
            #(ph);
            select(50);
            exp_q.push_back(rw);
            spi_frame(rw, 1, 50, got);
            check("t6_miso_word", got, tw);
            repeat (10) @(negedge clk);
            check("t6_rx_data", rx_data, rw);
        end

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
